pipe_stage_skid: RTL and testbench

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/sat_counter.sv | 32 +++
 rtl/pipe_stage_skid.sv | 97 +++++++++
 tb/tb_pipe_stage_skid.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the skid-buffered pipeline stage.
package pipe_pkg;

    localparam int unsigned DROP_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StBusy  = 2'd1,
        StFull  = 2'd2
    } pipe_state_e;

    // Number of entries held in a given state.
    function automatic logic [1:0] occupancy(input pipe_state_e st);
        unique case (st)
            StEmpty: occupancy = 2'd0;
            StBusy:  occupancy = 2'd1;
            StFull:  occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter advancing by 0, 1 or 2 per clock.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;
    logic [W+1:0] sum;
    logic [W+1:0] max_ext;

    always_comb begin
        // Two extra bits so the sum cannot wrap before the saturation compare.
        sum     = {2'b00, count_q} + {{W{1'b0}}, inc};
        max_ext = {2'b00, {W{1'b1}}};
        count_d = (sum > max_ext) ? {W{1'b1}} : sum[W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Fully registered valid/ready pipeline stage with a skid entry, flush and drop counter.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DROP_W = DROP_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [DROP_W-1:0] drop_count
);

    pipe_state_e      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_xfer;
    logic             out_xfer;
    logic [1:0]       drop_inc;

    // in_ready depends only on registered state, flush and reset.
    assign in_ready  = (state_q != StFull) && !flush && !reset;
    assign out_valid = (state_q != StEmpty);
    assign out_data  = main_q;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_comb begin
        state_d  = state_q;
        main_d   = main_q;
        skid_d   = skid_q;
        drop_inc = 2'd0;

        if (flush) begin
            // A beat leaving this cycle is delivered, not dropped.
            state_d  = StEmpty;
            main_d   = '0;
            skid_d   = '0;
            drop_inc = occupancy(state_q) - {1'b0, out_xfer};
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (in_xfer) begin
                        main_d  = in_data;
                        state_d = StBusy;
                    end
                end
                StBusy: begin
                    if (in_xfer && out_xfer) begin
                        main_d = in_data;
                    end else if (in_xfer) begin
                        skid_d  = in_data;
                        state_d = StFull;
                    end else if (out_xfer) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (out_xfer) begin
                        main_d  = skid_q;
                        state_d = StBusy;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    sat_counter #(
        .W(DROP_W)
    ) u_drop_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (drop_inc),
        .count(drop_count)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: streaming, backpressure, flush, saturation, async reset.
module tb_pipe_stage_skid;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [7:0]  drop_count;

    logic        s_flush;
    logic        s_in_valid;
    logic        s_in_ready;
    logic [7:0]  s_in_data;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [7:0]  s_out_data;
    logic [1:0]  s_drop_count;

    int n_pass = 0;
    int n_total = 0;

    pipe_stage_skid #(
        .WIDTH (32),
        .DROP_W(8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .drop_count(drop_count)
    );

    pipe_stage_skid #(
        .WIDTH (8),
        .DROP_W(2)
    ) dut_sat (
        .clk       (clk),
        .reset     (reset),
        .flush     (s_flush),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_data   (s_in_data),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_data  (s_out_data),
        .drop_count(s_drop_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        reset       = 1'b1;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b0;
        s_flush     = 1'b0;
        s_in_valid  = 1'b0;
        s_in_data   = '0;
        s_out_ready = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
        cyc();
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        cyc();

        // Streaming 1..4 with out_ready high
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            in_valid = (i <= 4);
            in_data  = 32'(i);
            @(negedge clk);
            if (i <= 4) chk("stream_in_ready", 64'(in_ready), 64'd1);
            if (i > 1) begin
                chk("stream_out_valid", 64'(out_valid), 64'd1);
                chk("stream_out_data", 64'(out_data), 64'(i - 1));
            end
            cyc();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("stream_drained", 64'(out_valid), 64'd0);
        cyc();

        // Backpressure: A then B while stalled
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        cyc();
        in_data = 32'hB;
        @(negedge clk);
        chk("bp_busy_in_ready", 64'(in_ready), 64'd1);
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_full_in_ready", 64'(in_ready), 64'd0);
        chk("bp_full_out_data", 64'(out_data), 64'hA);
        out_ready = 1'b1;
        cyc();
        @(negedge clk);
        chk("bp_second_in_ready", 64'(in_ready), 64'd1);
        chk("bp_second_out_data", 64'(out_data), 64'hB);
        cyc();
        @(negedge clk);
        chk("bp_drained", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        // Flush in FULL, no output transfer: +2
        in_valid = 1'b1;
        in_data  = 32'hC;
        cyc();
        in_data = 32'hD;
        cyc();
        in_valid = 1'b0;
        flush    = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        cyc();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_full_valid", 64'(out_valid), 64'd0);
        chk("flush_full_data", 64'(out_data), 64'd0);
        chk("flush_full_drop", 64'(drop_count), 64'd2);

        // Flush in FULL with output transfer: +1, main beat delivered
        in_valid = 1'b1;
        in_data  = 32'hE;
        cyc();
        in_data = 32'hF;
        cyc();
        in_valid  = 1'b0;
        flush     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("flush_out_data", 64'(out_data), 64'hE);
        chk("flush_out_valid", 64'(out_valid), 64'd1);
        cyc();
        flush     = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("flush_out_drop", 64'(drop_count), 64'd3);
        chk("flush_out_empty", 64'(out_valid), 64'd0);

        // Flush with in_valid: offered beat refused
        in_valid = 1'b1;
        in_data  = 32'h11;
        cyc();
        in_data = 32'h99;
        flush   = 1'b1;
        @(negedge clk);
        chk("flush_iv_in_ready", 64'(in_ready), 64'd0);
        cyc();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("flush_iv_drop", 64'(drop_count), 64'd4);
        chk("flush_iv_valid", 64'(out_valid), 64'd0);
        cyc();
        @(negedge clk);
        chk("flush_iv_no_beat", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        // Flush while EMPTY adds nothing
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_empty_drop", 64'(drop_count), 64'd4);

        // Saturation on the DROP_W=2 instance
        for (int k = 1; k <= 5; k++) begin
            s_in_valid = 1'b1;
            s_in_data  = 8'(k);
            cyc();
            s_in_valid = 1'b0;
            s_flush    = 1'b1;
            cyc();
            s_flush = 1'b0;
            @(negedge clk);
            chk("sat_drop", 64'(s_drop_count), 64'((k < 3) ? k : 3));
        end

        // Async reset between edges while FULL
        cyc();
        in_valid = 1'b1;
        in_data  = 32'h21;
        cyc();
        in_data = 32'h22;
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_full", 64'(in_ready), 64'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_drop", 64'(drop_count), 64'd0);
        chk("async_rst_in_ready", 64'(in_ready), 64'd0);
        cyc();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_release_in_ready", 64'(in_ready), 64'd1);
        chk("rst_release_data", 64'(out_data), 64'd0);
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
